pool_window_buffer: RTL and testbench

- Sink for the pooled/ReLU stream from the layer-1 maxpool stage: 3 channels of unsigned post-ReLU values, one raster-order beat per valid pulse, HALF_WIDTH x HALF_HEIGHT per frame.
- Buffers K-1 rows per channel and presents a full KxK window per channel to the layer-2 convolution, one window per accepted beat once a window is complete.
- No back-pressure: the block must accept every beat.

---
 rtl/pool_window_buffer.sv | 122 ++++++++++++
 tb/tb_pool_window_buffer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pool_window_buffer.sv
// Line-buffered KxK window generator for three pooled channels, one window per accepted beat.
// Optional synchronous frame realignment input 'flush' when POOL_WIN_FLUSH_EN is defined.
module pool_window_channel #(
    parameter int DATA_BIT   = 12,
    parameter int HALF_WIDTH = 12,
    parameter int K          = 5,
    parameter int CNT_BIT    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      shift,
    input  logic [CNT_BIT-1:0]        col,
    input  logic [DATA_BIT-1:0]       data_in,
    output logic [K*K*DATA_BIT-1:0]   window
);
    // lb[0] is the oldest buffered row
    logic [DATA_BIT-1:0] lb [K-1][HALF_WIDTH];
    logic [K*K*DATA_BIT-1:0] win;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win <= '0;
            for (int r = 0; r < K-1; r++)
                for (int x = 0; x < HALF_WIDTH; x++)
                    lb[r][x] <= '0;
        end else if (shift) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K-1; c++)
                    win[(r*K+c)*DATA_BIT +: DATA_BIT] <= win[(r*K+c+1)*DATA_BIT +: DATA_BIT];
                if (r < K-1)
                    win[(r*K+K-1)*DATA_BIT +: DATA_BIT] <= lb[r][col];
                else
                    win[(r*K+K-1)*DATA_BIT +: DATA_BIT] <= data_in;
            end
            for (int r = 0; r < K-2; r++)
                lb[r][col] <= lb[r+1][col];
            lb[K-2][col] <= data_in;
        end
    end

    assign window = win;
endmodule

module pool_window_buffer #(
    parameter int DATA_BIT    = 12,
    parameter int HALF_WIDTH  = 12,
    parameter int HALF_HEIGHT = 12,
    parameter int K           = 5,
    parameter int CNT_BIT     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef POOL_WIN_FLUSH_EN
    input  logic                     flush,
`endif
    input  logic                     valid_in,
    input  logic [DATA_BIT-1:0]      data_in_1,
    input  logic [DATA_BIT-1:0]      data_in_2,
    input  logic [DATA_BIT-1:0]      data_in_3,
    output logic [K*K*DATA_BIT-1:0]  window_1,
    output logic [K*K*DATA_BIT-1:0]  window_2,
    output logic [K*K*DATA_BIT-1:0]  window_3,
    output logic                     valid_out,
    output logic                     frame_done
);
    logic [CNT_BIT-1:0] col, row;
    logic clear, accept, last_col, last_row, win_ok;
    logic [2:0][DATA_BIT-1:0]     ch_data;
    logic [2:0][K*K*DATA_BIT-1:0] ch_win;

`ifdef POOL_WIN_FLUSH_EN
    assign clear = flush;
`else
    assign clear = 1'b0;
`endif

    assign accept   = valid_in && !clear;
    assign last_col = (col == CNT_BIT'(HALF_WIDTH-1));
    assign last_row = (row == CNT_BIT'(HALF_HEIGHT-1));
    // Row gating keeps stale previous-frame rows out of any reported window
    assign win_ok   = (row >= CNT_BIT'(K-1)) && (col >= CNT_BIT'(K-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else if (clear) begin
            col        <= '0;
            row        <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= accept && win_ok;
            frame_done <= accept && last_col && last_row;
            if (accept) begin
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    assign ch_data = {data_in_3, data_in_2, data_in_1};

    for (genvar g = 0; g < 3; g++) begin : g_ch
        pool_window_channel #(
            .DATA_BIT(DATA_BIT), .HALF_WIDTH(HALF_WIDTH), .K(K), .CNT_BIT(CNT_BIT)
        ) u_ch (
            .clk(clk), .rst(rst), .shift(accept), .col(col),
            .data_in(ch_data[g]), .window(ch_win[g])
        );
    end

    assign window_1 = ch_win[0];
    assign window_2 = ch_win[1];
    assign window_3 = ch_win[2];
endmodule

// File: tb/tb_pool_window_buffer.sv
// Directed bench for pool_window_buffer: full, gapped, back-to-back, reset-abort and flush frames.
module tb_pool_window_buffer;
    localparam int DW = 12;
    localparam int K  = 5;
    localparam int W  = K*K*DW;

    logic clk, rst, valid_in, valid_out, frame_done;
    logic [DW-1:0] data_in_1, data_in_2, data_in_3;
    logic [W-1:0]  window_1, window_2, window_3;
`ifdef POOL_WIN_FLUSH_EN
    logic flush;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    pool_window_buffer dut (
        .clk(clk), .rst(rst),
`ifdef POOL_WIN_FLUSH_EN
        .flush(flush),
`endif
        .valid_in(valid_in),
        .data_in_1(data_in_1), .data_in_2(data_in_2), .data_in_3(data_in_3),
        .window_1(window_1), .window_2(window_2), .window_3(window_3),
        .valid_out(valid_out), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected window for the raster pattern value = base + row*12 + col, scaled by mult
    function automatic logic [W-1:0] model_win(input int base, input int rr, input int cc, input int mult);
        logic [W-1:0] w;
        w = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                w[(r*K+c)*DW +: DW] = DW'(mult * (base + (rr-K+1+r)*12 + (cc-K+1+c)));
        return w;
    endfunction

    task automatic run_frame(input int base, input int gaps, input int nbeats);
        int nwin;
        logic [W-1:0] last_w;
        nwin = 0;
        for (int idx = 0; idx < nbeats; idx++) begin
            int rr, cc, v;
            logic expv;
            rr = idx / 12;
            cc = idx % 12;
            v  = base + idx;
            @(negedge clk);
            valid_in  = 1'b1;
            data_in_1 = DW'(v);
            data_in_2 = DW'(2*v);
            data_in_3 = '0;
            @(posedge clk); #1;
            expv = (rr >= 4) && (cc >= 4);
            chk("valid_out", W'(valid_out), W'(expv));
            chk("frame_done", W'(frame_done), W'(idx == 143));
            if (expv) begin
                nwin++;
                chk("window_1", window_1, model_win(base, rr, cc, 1));
                chk("window_2", window_2, model_win(base, rr, cc, 2));
                chk("window_3", window_3, '0);
            end
            if (base == 0 && idx == 52) begin
                chk("first_w00", W'(window_1[0 +: DW]), W'(0));
                chk("first_w04", W'(window_1[4*DW +: DW]), W'(4));
                chk("first_w40", W'(window_1[20*DW +: DW]), W'(48));
                chk("first_w44", W'(window_1[24*DW +: DW]), W'(52));
            end
            if (base == 0 && idx == 59) begin
                chk("edge_w44", W'(window_1[24*DW +: DW]), W'(59));
                chk("edge_w00", W'(window_1[0 +: DW]), W'(7));
            end
            if (base == 1000 && idx == 52) begin
                chk("f2_w00", W'(window_1[0 +: DW]), W'(1000));
                chk("f2_w44", W'(window_1[24*DW +: DW]), W'(1052));
            end
            last_w = window_1;
            for (int g = 0; g < gaps; g++) begin
                @(negedge clk);
                valid_in = 1'b0;
                @(posedge clk); #1;
                chk("gap_valid", W'(valid_out), '0);
                chk("gap_frame_done", W'(frame_done), '0);
                chk("gap_hold", window_1, last_w);
            end
        end
        if (nbeats == 144) chk("windows_per_frame", W'(nwin), W'(64));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid_in = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        valid_in = 1'b0;
        data_in_1 = '0; data_in_2 = '0; data_in_3 = '0;
`ifdef POOL_WIN_FLUSH_EN
        flush = 1'b0;
`endif
        #12;
        chk("rst_valid", W'(valid_out), '0);
        chk("rst_frame_done", W'(frame_done), '0);
        chk("rst_window_1", window_1, '0);
        chk("rst_window_3", window_3, '0);
        @(negedge clk);
        rst = 1'b0;

        run_frame(0, 0, 144);
        idle(2);
        run_frame(0, 3, 144);
        run_frame(0, 0, 144);
        run_frame(1000, 0, 144);
        idle(2);

        run_frame(0, 0, 30);
        @(negedge clk);
        valid_in = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_valid", W'(valid_out), '0);
        chk("midrst_window_1", window_1, '0);
        chk("midrst_window_2", window_2, '0);
        @(negedge clk);
        rst = 1'b0;
        run_frame(0, 0, 144);
        idle(2);

`ifdef POOL_WIN_FLUSH_EN
        run_frame(0, 0, 70);
        @(negedge clk);
        flush = 1'b1;
        valid_in = 1'b1;
        data_in_1 = DW'(777);
        data_in_2 = DW'(777);
        @(posedge clk); #1;
        chk("flush_valid", W'(valid_out), '0);
        chk("flush_frame_done", W'(frame_done), '0);
        @(negedge clk);
        flush = 1'b0;
        valid_in = 1'b0;
        run_frame(0, 0, 144);
        idle(2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
